// File: rtl/lc_cfg_loader.sv
// Serial configuration loader: shifts per-cell config words into a shadow register, length/mode checked, commits atomically.
// Optional build macro LC_CFG_PARITY_EN appends an even-parity bit to the stream and checks it before commit.
module lc_cfg_loader #(
   parameter int unsigned NUM_CELLS = 4,
   parameter int unsigned CFG_BITS  = 21,
   parameter int unsigned CNT_W     = 8
) (
   input  logic                          QCK,
   input  logic                          QRN,
   input  logic                          cfg_valid,
   output logic                          cfg_ready,
   input  logic                          cfg_bit,
   input  logic                          cfg_last,
   input  logic                          cfg_abort,
   output logic [NUM_CELLS*CFG_BITS-1:0] cfg_out,
   output logic                          cfg_done,
   output logic                          cfg_err
);

   localparam int unsigned TOTAL = NUM_CELLS * CFG_BITS;
`ifdef LC_CFG_PARITY_EN
   localparam int unsigned LEN_LAST = TOTAL;
`else
   localparam int unsigned LEN_LAST = TOTAL - 1;
`endif

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SHIFT,
      ST_CHECK,
      ST_COMMIT,
      ST_ERROR
   } state_e;

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [TOTAL-1:0]   shadow_q, shadow_d;
   logic [TOTAL-1:0]   out_q, out_d;
   logic               ready_q, ready_d;
   logic               done_q, done_d;
   logic               err_q, err_d;
   logic               accept;
   logic               mode_bad;
   logic               par_bad;
   logic               at_last;

`ifdef LC_CFG_PARITY_EN
   // Running XOR over every accepted bit; zero at the end means even parity holds.
   logic par_q, par_d;
   always_ff @(posedge QCK or negedge QRN) begin
      if (!QRN) par_q <= 1'b0;
      else      par_q <= par_d;
   end
   always_comb begin
      par_d = par_q;
      if (accept && state_q == ST_IDLE)       par_d = cfg_bit;
      else if (accept && state_q == ST_SHIFT) par_d = par_q ^ cfg_bit;
   end
   assign par_bad = par_q;
`else
   assign par_bad = 1'b0;
`endif

   always_ff @(posedge QCK or negedge QRN) begin
      if (!QRN) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         shadow_q <= '0;
         out_q    <= '0;
         ready_q  <= 1'b0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         shadow_q <= shadow_d;
         out_q    <= out_d;
         ready_q  <= ready_d;
         done_q   <= done_d;
         err_q    <= err_d;
      end
   end

   // Abort wins over a simultaneous valid bit.
   assign accept  = cfg_valid && ready_q && !cfg_abort;
   assign at_last = (cnt_q == CNT_W'(LEN_LAST));

   always_comb begin
      mode_bad = 1'b0;
      for (int unsigned c = 0; c < NUM_CELLS; c++) begin
         if (shadow_q[c*CFG_BITS+16 +: 2] == 2'b11) mode_bad = 1'b1;
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      shadow_d = shadow_q;
      out_d    = out_q;
      done_d   = 1'b0;
      err_d    = err_q;
      unique case (state_q)
         ST_IDLE: begin
            if (accept) begin
               shadow_d[0] = cfg_bit;
               cnt_d       = CNT_W'(1);
               err_d       = 1'b0;
               if (LEN_LAST == 0) state_d = cfg_last ? ST_CHECK : ST_ERROR;
               else               state_d = cfg_last ? ST_ERROR : ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            if (cfg_abort) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end else if (accept) begin
               for (int unsigned i = 0; i < TOTAL; i++) begin
                  if (cnt_q == CNT_W'(i)) shadow_d[i] = cfg_bit;
               end
               cnt_d = cnt_q + CNT_W'(1);
               if (at_last)       state_d = cfg_last ? ST_CHECK : ST_ERROR;
               else if (cfg_last) state_d = ST_ERROR;
            end
         end
         ST_CHECK: begin
            if (cfg_abort) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end else if (mode_bad || par_bad) begin
               state_d = ST_ERROR;
            end else begin
               state_d = ST_COMMIT;
            end
         end
         ST_COMMIT: begin
            out_d   = shadow_q;
            done_d  = 1'b1;
            cnt_d   = '0;
            state_d = ST_IDLE;
         end
         ST_ERROR: begin
            cnt_d   = '0;
            state_d = ST_IDLE;
         end
         default: begin
            cnt_d   = '0;
            state_d = ST_IDLE;
         end
      endcase
      if (state_d == ST_ERROR) err_d = 1'b1;
      ready_d = (state_d == ST_IDLE) || (state_d == ST_SHIFT);
   end

   assign cfg_ready = ready_q;
   assign cfg_out   = out_q;
   assign cfg_done  = done_q;
   assign cfg_err   = err_q;

endmodule

// File: tb/tb_lc_cfg_loader.sv
// Directed bench for lc_cfg_loader: commit latency, length/mode errors, abort, gapped valid, overrun, async reset.
module tb_lc_cfg_loader;
   localparam int unsigned TOTAL = 84;
`ifdef LC_CFG_PARITY_EN
   localparam int NBITS = TOTAL + 1;
`else
   localparam int NBITS = TOTAL;
`endif

   logic             QCK = 1'b0;
   logic             QRN = 1'b0;
   logic             cfg_valid = 1'b0;
   logic             cfg_bit = 1'b0;
   logic             cfg_last = 1'b0;
   logic             cfg_abort = 1'b0;
   logic             cfg_ready;
   logic             cfg_done;
   logic             cfg_err;
   logic [TOTAL-1:0] cfg_out;

   int               total = 0;
   int               bad = 0;
   int               ready_drops = 0;
   logic [TOTAL-1:0] exp_out = '0;

   lc_cfg_loader #(.NUM_CELLS(4), .CFG_BITS(21), .CNT_W(8)) dut (
      .QCK(QCK), .QRN(QRN), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
      .cfg_bit(cfg_bit), .cfg_last(cfg_last), .cfg_abort(cfg_abort),
      .cfg_out(cfg_out), .cfg_done(cfg_done), .cfg_err(cfg_err)
   );

   always #5 QCK = ~QCK;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
      $fatal(1, "watchdog");
   end

   // Stream image: data bits plus an even-parity bit (optionally flipped) at index TOTAL.
   function automatic logic [TOTAL:0] mkstream(input logic [TOTAL-1:0] d, input logic flip);
      mkstream = {(^d) ^ flip, d};
   endfunction

   task automatic send_bit(input logic b, input logic l);
      int waited = 0;
      @(negedge QCK);
      cfg_valid = 1'b1; cfg_bit = b; cfg_last = l;
      while (cfg_ready !== 1'b1 && waited < 20) begin
         @(negedge QCK);
         waited++;
      end
      if (waited >= 20) begin
         total++; bad++;
         $display("FAIL send_timeout: cfg_ready=%b after %0d cycles, want 1", cfg_ready, waited);
      end
      @(posedge QCK);
      #1;
      cfg_valid = 1'b0; cfg_last = 1'b0;
   endtask

   task automatic send_range(input logic [TOTAL:0] s, input int from, input int to,
                             input int last_idx, input bit gaps);
      for (int i = from; i <= to; i++) begin
         if (gaps) begin
            int g;
            g = int'($urandom_range(0, 2));
            repeat (g) begin
               @(negedge QCK);
               if (cfg_ready !== 1'b1) ready_drops++;
            end
         end
         send_bit(s[7'(i)], i == last_idx);
      end
   endtask

   task automatic test_reset;
      repeat (2) @(posedge QCK);
      @(negedge QCK);
      total++; if (cfg_out !== '0) begin bad++; $display("FAIL reset_out: got %h want 0", cfg_out); end
      total++; if ({cfg_ready, cfg_done, cfg_err} !== 3'b000) begin
         bad++; $display("FAIL reset_flags: ready/done/err=%b want 000", {cfg_ready, cfg_done, cfg_err}); end
      QRN = 1'b1;
      #1;
      total++; if (cfg_ready !== 1'b0) begin bad++; $display("FAIL reset_release_early: ready=%b want 0", cfg_ready); end
      @(posedge QCK); #1;
      total++; if (cfg_ready !== 1'b1) begin bad++; $display("FAIL reset_release: ready=%b want 1", cfg_ready); end
   endtask

   task automatic test_commit;
      logic [TOTAL-1:0] d = '0;
      d[15:0] = 16'hA55A;
      send_range(mkstream(d, 1'b0), 0, NBITS-1, NBITS-1, 1'b0);
      @(negedge QCK);
      total++; if (cfg_done !== 1'b0 || cfg_out !== exp_out) begin
         bad++; $display("FAIL commit_e0: done=%b out=%h want done=0 out=%h", cfg_done, cfg_out, exp_out); end
      @(negedge QCK);
      total++; if (cfg_done !== 1'b0 || cfg_ready !== 1'b0 || cfg_out !== exp_out) begin
         bad++; $display("FAIL commit_e1: done=%b ready=%b out=%h want 0 0 %h", cfg_done, cfg_ready, cfg_out, exp_out); end
      @(negedge QCK);
      exp_out = d;
      total++; if (cfg_done !== 1'b1 || cfg_out !== exp_out || cfg_err !== 1'b0) begin
         bad++; $display("FAIL commit_e2: done=%b err=%b out=%h want 1 0 %h", cfg_done, cfg_err, cfg_out, exp_out); end
      @(negedge QCK);
      total++; if (cfg_done !== 1'b0 || cfg_ready !== 1'b1) begin
         bad++; $display("FAIL commit_e3: done=%b ready=%b want 0 1", cfg_done, cfg_ready); end
   endtask

   task automatic test_short;
      logic [TOTAL-1:0] d = {3{28'h5F0_0C3A}};
      send_range(mkstream(d, 1'b0), 0, 40, 40, 1'b0);
      @(negedge QCK);
      total++; if (cfg_err !== 1'b1 || cfg_ready !== 1'b0) begin
         bad++; $display("FAIL short_err: err=%b ready=%b want 1 0", cfg_err, cfg_ready); end
      @(negedge QCK);
      total++; if (cfg_err !== 1'b1 || cfg_ready !== 1'b1 || cfg_done !== 1'b0 || cfg_out !== exp_out) begin
         bad++; $display("FAIL short_idle: err=%b ready=%b done=%b out=%h want 1 1 0 %h",
                         cfg_err, cfg_ready, cfg_done, cfg_out, exp_out); end
   endtask

   task automatic test_mode3;
      logic [TOTAL-1:0] d = '0;
      int dones = 0;
      d[15:0] = 16'h1234;
      d[59:58] = 2'b11;
      send_range(mkstream(d, 1'b0), 0, NBITS-1, NBITS-1, 1'b0);
      repeat (4) begin
         @(negedge QCK);
         if (cfg_done !== 1'b0) dones++;
      end
      total++; if (dones != 0) begin bad++; $display("FAIL mode3_done: pulses=%0d want 0", dones); end
      total++; if (cfg_err !== 1'b1 || cfg_out !== exp_out) begin
         bad++; $display("FAIL mode3_err: err=%b out=%h want 1 %h", cfg_err, cfg_out, exp_out); end
   endtask

   task automatic test_abort;
      logic [TOTAL-1:0] d2 = {21'h0, 21'h00ABC, 21'h0F00F, 21'h1FFFF};
      logic [TOTAL-1:0] d3 = {21'h00777, 21'h0, 21'h1CAFE, 21'h0BEEF};
      logic [TOTAL:0]   s2 = mkstream(d2, 1'b0);
      send_range(s2, 0, 0, -1, 1'b0);
      @(negedge QCK);
      total++; if (cfg_err !== 1'b0) begin bad++; $display("FAIL abort_err_clear: err=%b want 0", cfg_err); end
      send_range(s2, 1, 49, -1, 1'b0);
      @(negedge QCK);
      cfg_valid = 1'b1; cfg_abort = 1'b1; cfg_bit = ~s2[50];
      @(posedge QCK); #1;
      cfg_valid = 1'b0; cfg_abort = 1'b0;
      @(negedge QCK);
      total++; if (cfg_ready !== 1'b1 || cfg_err !== 1'b0 || cfg_done !== 1'b0 || cfg_out !== exp_out) begin
         bad++; $display("FAIL abort_idle: ready=%b err=%b done=%b out=%h want 1 0 0 %h",
                         cfg_ready, cfg_err, cfg_done, cfg_out, exp_out); end
      send_range(mkstream(d3, 1'b0), 0, NBITS-1, NBITS-1, 1'b0);
      repeat (3) @(negedge QCK);
      exp_out = d3;
      total++; if (cfg_done !== 1'b1 || cfg_err !== 1'b0 || cfg_out !== exp_out) begin
         bad++; $display("FAIL abort_fresh: done=%b err=%b out=%h want 1 0 %h", cfg_done, cfg_err, cfg_out, exp_out); end
   endtask

   task automatic test_random_valid;
      logic [TOTAL-1:0] d;
      d = {$urandom, $urandom, $urandom};
      for (int c = 0; c < 4; c++) d[c*21+17] = 1'b0;
      ready_drops = 0;
      send_range(mkstream(d, 1'b0), 0, NBITS-1, NBITS-1, 1'b1);
      total++; if (ready_drops != 0) begin bad++; $display("FAIL random_ready: drops=%0d want 0", ready_drops); end
      repeat (3) @(negedge QCK);
      exp_out = d;
      total++; if (cfg_done !== 1'b1 || cfg_out !== exp_out) begin
         bad++; $display("FAIL random_commit: done=%b out=%h want 1 %h", cfg_done, cfg_out, exp_out); end
   endtask

   task automatic test_overrun;
      logic [TOTAL-1:0] d = {TOTAL{1'b0}};
      d[20:0] = 21'h0_5A5A;
      send_range(mkstream(d, 1'b0), 0, NBITS-1, -1, 1'b0);
      @(negedge QCK);
      total++; if (cfg_err !== 1'b1 || cfg_ready !== 1'b0) begin
         bad++; $display("FAIL overrun_err: err=%b ready=%b want 1 0", cfg_err, cfg_ready); end
      repeat (2) @(negedge QCK);
      total++; if (cfg_done !== 1'b0 || cfg_out !== exp_out) begin
         bad++; $display("FAIL overrun_out: done=%b out=%h want 0 %h", cfg_done, cfg_out, exp_out); end
   endtask

   task automatic test_reset_midstream;
      logic [TOTAL-1:0] d = {21'h0_1111, 21'h0_2222, 21'h0_3333, 21'h0_4444};
      logic [TOTAL:0]   s = mkstream(d, 1'b0);
      send_range(s, 0, 29, -1, 1'b0);
      #2;
      QRN = 1'b0;
      #1;
      exp_out = '0;
      total++; if (cfg_out !== exp_out || {cfg_ready, cfg_done, cfg_err} !== 3'b000) begin
         bad++; $display("FAIL midreset: out=%h rdy/done/err=%b want 0 000", cfg_out, {cfg_ready, cfg_done, cfg_err}); end
      @(negedge QCK);
      QRN = 1'b1;
      send_range(s, 0, NBITS-1, NBITS-1, 1'b0);
      repeat (3) @(negedge QCK);
      exp_out = d;
      total++; if (cfg_done !== 1'b1 || cfg_out !== exp_out) begin
         bad++; $display("FAIL midreset_restart: done=%b out=%h want 1 %h", cfg_done, cfg_out, exp_out); end
   endtask

`ifdef LC_CFG_PARITY_EN
   task automatic test_parity;
      logic [TOTAL-1:0] d = {21'h0_ABCD, 21'h1_0001, 21'h0_8000, 21'h0_00FF};
      send_range(mkstream(d, 1'b1), 0, NBITS-1, NBITS-1, 1'b0);
      repeat (3) @(negedge QCK);
      total++; if (cfg_err !== 1'b1 || cfg_done !== 1'b0 || cfg_out !== exp_out) begin
         bad++; $display("FAIL parity_bad: err=%b done=%b out=%h want 1 0 %h", cfg_err, cfg_done, cfg_out, exp_out); end
      send_range(mkstream(d, 1'b0), 0, NBITS-1, NBITS-1, 1'b0);
      repeat (3) @(negedge QCK);
      exp_out = d;
      total++; if (cfg_err !== 1'b0 || cfg_done !== 1'b1 || cfg_out !== exp_out) begin
         bad++; $display("FAIL parity_good: err=%b done=%b out=%h want 0 1 %h", cfg_err, cfg_done, cfg_out, exp_out); end
   endtask
`endif

   initial begin
      test_reset();
      test_commit();
      test_short();
      test_mode3();
      test_abort();
      test_random_valid();
      test_overrun();
      test_reset_midstream();
`ifdef LC_CFG_PARITY_EN
      test_parity();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/lc_cfg_loader.md
Name: lc_cfg_loader

Overview:
- Serial configuration loader sitting directly upstream of a column of logic cells.
- Shifts in a per-cell configuration word and holds it in a shadow register: LUT truth table, mode, and QDI/BQZ/CQZ mux selects.
- On a length-checked commit, transfers the shadow register atomically to the parallel outputs that drive the cells' configuration inputs.
- Lets a partially shifted stream never reach the cells, and lets cells be reconfigured without glitching the live configuration.

Parameters:
- NUM_CELLS, 4, number of logic cells fed by this loader.
- CFG_BITS, 21, bits per cell. Layout, LSB first: [15:0] LUT init, [17:16] mode (0=LUT_FF, 1=LUT_FF_Separate, 2=LUT_ADDER, 3=reserved), [18] QDI_MUX, [19] BQZ_MUX, [20] CQZ_MUX.
- CNT_W, 8, width of the bit counter; must satisfy 2^CNT_W > NUM_CELLS*CFG_BITS.

Ports:
- QCK  input  1  clock, rising edge.
- QRN  input  1  asynchronous active-low reset.
- cfg_valid  input  1  serial bit valid.
- cfg_ready  output  1  loader accepts a bit this cycle.
- cfg_bit  input  1  serial data; stream is cell 0 first, LSB first.
- cfg_last  input  1  marks the final bit of the stream.
- cfg_abort  input  1  discard the shadow register and return to IDLE.
- cfg_out  output  NUM_CELLS*CFG_BITS  committed configuration; cell i occupies [i*CFG_BITS +: CFG_BITS].
- cfg_done  output  1  one-cycle pulse when a commit completes.
- cfg_err  output  1  sticky error flag, cleared by the next accepted first bit.

Behaviour:
- Reset, asserted asynchronously on QRN=0:
  - state=IDLE, counter=0, shadow=0, cfg_out=0 (all cells LUT_FF, LUT init 0).
  - cfg_ready=0, cfg_done=0, cfg_err=0.
- The release of QRN takes effect at the first QCK edge after deassertion.
- A bit is accepted on a cycle with cfg_valid && cfg_ready. No bits are accepted while not ready; the source must hold valid/bit/last stable until accepted.
- States:
  - IDLE: cfg_ready=1. An accepted bit is written to shadow[0], counter=1, cfg_err cleared, go to SHIFT. If cfg_last is set on that first bit, go to ERROR instead, unless NUM_CELLS*CFG_BITS==1.
  - SHIFT: cfg_ready=1. An accepted bit is written to shadow[counter] and the counter increments.
    - cfg_last on the bit with counter==TOTAL-1 (TOTAL=NUM_CELLS*CFG_BITS): go to CHECK.
    - cfg_last on any earlier bit: go to ERROR.
    - Bit accepted with counter==TOTAL-1 and cfg_last=0 (overrun): go to ERROR.
  - CHECK: cfg_ready=0; lasts 1 cycle. If any cell's mode field equals 3, go to ERROR; otherwise go to COMMIT.
  - COMMIT: cfg_ready=0; lasts 1 cycle. cfg_out <= shadow in one edge, all bits together. cfg_done=1 for exactly this cycle's registered output; then go to IDLE, counter=0.
  - ERROR: cfg_ready=0, cfg_err=1; cfg_out is unchanged. Next cycle go to IDLE with cfg_err still held at 1.
- Latency: cfg_out updates 2 cycles after the edge accepting the last bit; cfg_done is high in the same cycle as the new cfg_out.
- cfg_abort:
  - In SHIFT or CHECK: next state IDLE, counter=0, shadow unchanged but treated as invalid, cfg_out unchanged, no cfg_err.
  - cfg_abort has priority over a simultaneous accepted bit.
  - Ignored in COMMIT; the commit completes.
- cfg_out changes only in COMMIT and on reset. Reset in mid-stream or mid-commit clears everything, including cfg_out.
- Counter never wraps; overrun is handled by the ERROR path.

Optional Feature:
- LC_CFG_PARITY_EN defined:
  - The stream carries TOTAL+1 bits; the final bit (the one with cfg_last) is even parity over the TOTAL data bits.
  - CHECK additionally fails to ERROR on a parity mismatch.
  - The length rule becomes: cfg_last required at counter==TOTAL.
- Undefined: no parity bit; the length is exactly TOTAL.

Test Plan:
- Reset then 84 bits with cell0 LUT=16'hA55A, mode=0, all others 0, cfg_last on bit 83 -> cfg_out[15:0]=16'hA55A, remaining bits 0, cfg_done pulse at 2 cycles after the last accept, cfg_err=0.
- cfg_last on bit 40 -> cfg_err=1, cfg_out keeps its previous value, loader in IDLE with cfg_ready=1 next cycle.
- Valid stream with cell2 mode=3 -> cfg_err=1 and no cfg_done.
- cfg_abort asserted at bit 50 together with cfg_valid -> that bit is not stored, counter=0, then a full fresh stream commits correctly.
- Valid toggling randomly, with ready dropping only in CHECK/COMMIT -> committed word equals the sent word; QRN pulled low mid-stream -> cfg_out=0 immediately.
- With LC_CFG_PARITY_EN: 85 bits with wrong parity -> cfg_err=1; correct parity -> commit.
